// File: rtl/rs_syndrome_serial_pkg.sv
// rtl/rs_syndrome_serial_pkg.sv - shared GF(2^m) defaults and elaboration-time helpers
package rs_pkg;

    localparam int          SYMBOL_WIDTH_DEF = 8;
    localparam int unsigned PRIM_POLY_DEF    = 32'h11D;

    function automatic int clog2(input int value);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Field degree is taken from the highest set bit of the primitive polynomial.
    function automatic int unsigned gf_mul(input int unsigned a, input int unsigned b,
                                           input int unsigned poly);
        int unsigned w   = 0;
        int unsigned acc = 0;
        int unsigned x   = a;
        for (int i = 0; i < 32; i++) begin
            if (poly[i]) w = i;
        end
        for (int i = 0; i < 32; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x << 1;
            if (x[w]) x = x ^ poly;
        end
        return acc;
    endfunction

    function automatic int unsigned gf_pow_alpha(input int j, input int unsigned poly);
        int unsigned r = 1;
        for (int i = 0; i < j; i++) begin
            r = gf_mul(r, 2, poly);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_syndrome_serial_if.sv
// rtl/rs_syndrome_serial_if.sv - symbol input and syndrome result handshakes
interface rs_syndrome_serial_if #(
    parameter int SYMBOL_WIDTH = 8,
    parameter int NUM_SYND     = 2
);
    logic                             in_valid;
    logic                             in_ready;
    logic [SYMBOL_WIDTH-1:0]          in_sym;
    logic                             in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_SYND*SYMBOL_WIDTH-1:0] out_synd;
    logic                             out_err;
    logic                             out_len_err;

    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_synd, out_err, out_len_err
    );

    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_synd, out_err, out_len_err
    );
endinterface

// File: rtl/rs_syndrome_serial_cell.sv
// rtl/rs_syndrome_serial_cell.sv - one Horner accumulator evaluating v(alpha^J)
module rs_syndrome_cell
    import rs_pkg::*;
#(
    parameter int          SYMBOL_WIDTH = SYMBOL_WIDTH_DEF,
    parameter int          J            = 1,
    parameter int unsigned PRIM_POLY    = PRIM_POLY_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    en,
    input  logic [SYMBOL_WIDTH-1:0] sym,
    output logic [SYMBOL_WIDTH-1:0] s,
    output logic [SYMBOL_WIDTH-1:0] s_next
);

    localparam int unsigned COEF = gf_pow_alpha(J, PRIM_POLY);

    logic [SYMBOL_WIDTH-1:0] r_s;
    logic [SYMBOL_WIDTH-1:0] w_term [SYMBOL_WIDTH];
    logic [SYMBOL_WIDTH-1:0] w_prod;

    // Column k of the constant multiplier is alpha^J * x^k.
    for (genvar k = 0; k < SYMBOL_WIDTH; k++) begin : g_col
        localparam logic [SYMBOL_WIDTH-1:0] COL =
            SYMBOL_WIDTH'(gf_mul(32'd1 << k, COEF, PRIM_POLY));
        assign w_term[k] = r_s[k] ? COL : '0;
    end

    always_comb begin
        w_prod = '0;
        for (int k = 0; k < SYMBOL_WIDTH; k++) begin
            w_prod = w_prod ^ w_term[k];
        end
    end

    assign s_next = load ? sym : (w_prod ^ sym);
    assign s      = r_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s <= '0;
        end else if (en) begin
            r_s <= s_next;
        end
    end

endmodule

// File: rtl/rs_syndrome_serial.sv
// rtl/rs_syndrome_serial.sv - symbol-serial Reed-Solomon syndrome generator
module rs_syndrome_serial
    import rs_pkg::*;
#(
    parameter int          SYMBOL_WIDTH = SYMBOL_WIDTH_DEF,
    parameter int          N            = 18,
    parameter int          NUM_SYND     = 2,
    parameter int unsigned PRIM_POLY    = PRIM_POLY_DEF
) (
    input  logic                clk,
    input  logic                reset,
    rs_syndrome_serial_if.slave bus
);

    localparam int CNT_W = clog2(N + 1);
    localparam int OW    = NUM_SYND * SYMBOL_WIDTH;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [OW-1:0]    r_out_synd;
    logic             r_out_err;
    logic             r_out_len_err;
    logic             r_hold_len_err;

    logic [OW-1:0]    w_acc;
    logic [OW-1:0]    w_acc_next;
    logic             w_fire;
    logic             w_last_pos;
    logic             w_term;
    logic             w_len_err;
    logic             w_out_free;
    logic             w_release;

    assign w_fire     = bus.in_valid && (r_state == ST_ACCUM);
    assign w_last_pos = (r_cnt == CNT_W'(N - 1));
    assign w_term     = w_fire && (bus.in_last || w_last_pos);
    assign w_len_err  = !(w_last_pos && bus.in_last);
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_release  = (r_state == ST_HOLD) && r_out_valid && bus.out_ready;

    for (genvar g = 0; g < NUM_SYND; g++) begin : g_cell
        rs_syndrome_cell #(
            .SYMBOL_WIDTH (SYMBOL_WIDTH),
            .J            (g + 1),
            .PRIM_POLY    (PRIM_POLY)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .load   (r_cnt == '0),
            .en     (w_fire),
            .sym    (bus.in_sym),
            .s      (w_acc[g*SYMBOL_WIDTH +: SYMBOL_WIDTH]),
            .s_next (w_acc_next[g*SYMBOL_WIDTH +: SYMBOL_WIDTH])
        );
    end

    // A blocked frame stays in the accumulators until the output register frees up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_ACCUM;
            r_cnt          <= '0;
            r_out_valid    <= 1'b0;
            r_out_synd     <= '0;
            r_out_err      <= 1'b0;
            r_out_len_err  <= 1'b0;
            r_hold_len_err <= 1'b0;
        end else begin
            if (w_fire) begin
                r_cnt <= w_term ? '0 : r_cnt + 1'b1;
            end

            if (w_term && w_out_free) begin
                r_out_valid   <= 1'b1;
                r_out_synd    <= w_acc_next;
                r_out_err     <= |w_acc_next;
                r_out_len_err <= w_len_err;
            end else if (w_release) begin
                r_out_valid   <= 1'b1;
                r_out_synd    <= w_acc;
                r_out_err     <= |w_acc;
                r_out_len_err <= r_hold_len_err;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid   <= 1'b0;
            end

            if (w_term && !w_out_free) begin
                r_state        <= ST_HOLD;
                r_hold_len_err <= w_len_err;
            end else if (w_release) begin
                r_state        <= ST_ACCUM;
            end
        end
    end

    assign bus.in_ready    = (r_state == ST_ACCUM);
    assign bus.out_valid   = r_out_valid;
    assign bus.out_synd    = r_out_synd;
    assign bus.out_err     = r_out_err;
    assign bus.out_len_err = r_out_len_err;

endmodule

// File: tb/tb_rs_syndrome_serial.sv
// tb/tb_rs_syndrome_serial.sv - self-checking bench for rs_syndrome_serial
module tb_rs_syndrome_serial;

    localparam int SW = 8;
    localparam int N  = 18;
    localparam int NS = 2;

    typedef struct {
        logic [15:0] synd;
        logic        err;
        logic        len;
    } res_t;

    typedef struct {
        int          nbeats;
        int          last_at;
        int          pos;
        logic [7:0]  val;
        logic [15:0] synd;
        logic        err;
        logic        len;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int         n_vec   = 0;
    int         n_miss  = 0;
    res_t       q[$];
    res_t       mon_e;
    logic [7:0] fb [N];
    bit         rand_bp  = 1'b0;
    logic       or_force = 1'b1;

    rs_syndrome_serial_if #(.SYMBOL_WIDTH(SW), .NUM_SYND(NS)) bus ();

    rs_syndrome_serial #(
        .SYMBOL_WIDTH (SW),
        .N            (N),
        .NUM_SYND     (NS),
        .PRIM_POLY    (32'h11D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : or_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got synd %h expected no output", bus.out_synd);
            end else begin
                mon_e = q.pop_front();
                check("out_synd", 32'(bus.out_synd), 32'(mon_e.synd));
                check("out_err", 32'(bus.out_err), 32'(mon_e.err));
                check("out_len_err", 32'(bus.out_len_err), 32'(mon_e.len));
            end
        end
    end

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] model_synd(input int nb);
        logic [7:0] s1 = 8'h00;
        logic [7:0] s2 = 8'h00;
        for (int k = 0; k < nb; k++) begin
            s1 = tb_mul(s1, 8'h02) ^ fb[k];
            s2 = tb_mul(s2, 8'h04) ^ fb[k];
        end
        return {s2, s1};
    endfunction

    task automatic push_model(input int nb, input logic len);
        res_t r;
        r.synd = model_synd(nb);
        r.err  = |r.synd;
        r.len  = len;
        q.push_back(r);
    endtask

    task automatic make_codeword();
        logic [7:0] r1 = 8'h00;
        logic [7:0] r0 = 8'h00;
        logic [7:0] f;
        for (int k = 0; k < N - 2; k++) begin
            fb[k] = 8'($urandom);
            f  = fb[k] ^ r1;
            r1 = r0 ^ tb_mul(f, 8'h06);
            r0 = tb_mul(f, 8'h08);
        end
        fb[N-2] = r1;
        fb[N-1] = r0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [7:0] sym, input logic last);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sym   = sym;
        bus.in_last  = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_miss++;
            $display("FAIL in_ready_timeout: in_ready 0 for 200 cycles, expected 1");
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) begin
            drive_beat(fb[k], (k + 1) == last_at);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[8];
        res_t       r;
        logic [15:0] snap;
        int         k;

        tbl[0] = '{18, 18,  0, 8'h00, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{18, 18, 18, 8'h01, 16'h0101, 1'b1, 1'b0};
        tbl[2] = '{18, 18, 17, 8'h01, 16'h0402, 1'b1, 1'b0};
        tbl[3] = '{10, 10, 10, 8'h01, 16'h0101, 1'b1, 1'b1};
        tbl[4] = '{18, 18,  0, 8'h00, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{18,  0,  0, 8'h00, 16'h0000, 1'b0, 1'b1};
        tbl[6] = '{18, 18,  1, 8'h01, 16'h4E98, 1'b1, 1'b0};
        tbl[7] = '{ 1,  1,  1, 8'h5A, 16'h5A5A, 1'b1, 1'b1};

        bus.in_valid = 1'b0;
        bus.in_sym   = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_synd", 32'(bus.out_synd), 32'd0);
        check("reset_out_err", 32'(bus.out_err), 32'd0);
        check("reset_out_len_err", 32'(bus.out_len_err), 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < N; j++) fb[j] = 8'h00;
            if (tbl[i].pos != 0) fb[tbl[i].pos - 1] = tbl[i].val;
            r.synd = tbl[i].synd;
            r.err  = tbl[i].err;
            r.len  = tbl[i].len;
            q.push_back(r);
            send_frame(tbl[i].nbeats, tbl[i].last_at);
            if (i == 0) begin
                @(negedge clk);
                check("latency_out_valid", 32'(bus.out_valid), 32'd1);
                tick();
            end
        end
        drain();

        for (int f = 0; f < 100; f++) begin
            make_codeword();
            r.synd = 16'h0000;
            r.err  = 1'b0;
            r.len  = 1'b0;
            q.push_back(r);
            send_frame(N, N);
        end
        drain();

        rand_bp = 1'b1;
        for (int f = 0; f < 100; f++) begin
            make_codeword();
            k = $urandom_range(0, N - 1);
            fb[k] = fb[k] ^ 8'($urandom_range(1, 255));
            push_model(N, 1'b0);
            send_frame(N, N);
        end
        rand_bp = 1'b0;
        drain();

        or_force = 1'b0;
        repeat (2) tick();
        for (int j = 0; j < N; j++) fb[j] = 8'($urandom_range(1, 255));
        push_model(N, 1'b0);
        send_frame(N, N);
        @(negedge clk);
        check("hold_first_valid", 32'(bus.out_valid), 32'd1);
        snap = bus.out_synd;
        tick();
        for (int j = 0; j < N; j++) fb[j] = 8'($urandom_range(1, 255));
        push_model(N, 1'b0);
        send_frame(N, N);
        @(negedge clk);
        check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        check("hold_stable_a", 32'(bus.out_synd), 32'(snap));
        tick();
        repeat (8) tick();
        @(negedge clk);
        check("hold_stable_b", 32'(bus.out_synd), 32'(snap));
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        tick();
        or_force = 1'b1;
        drain();
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        for (int j = 0; j < N; j++) fb[j] = 8'($urandom);
        for (int j = 0; j < 9; j++) drive_beat(fb[j], 1'b0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        repeat (5) tick();
        for (int j = 0; j < N; j++) fb[j] = 8'($urandom);
        push_model(N, 1'b0);
        send_frame(N, N);
        drain();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
